// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the instruction fetch / next-PC unit.
// Holds the FSM state encoding, instruction field positions and opcode values.
package fetch_pc_unit_pkg;

   localparam int INSTR_W   = 32;
   localparam int OPCODE_HI = 31;
   localparam int OPCODE_LO = 26;
   localparam int TARGET_HI = 25;
   localparam int TARGET_LO = 0;
   localparam int IMM_HI    = 15;
   localparam int IMM_LO    = 0;
   localparam int FUNCT_HI  = 5;
   localparam int FUNCT_LO  = 0;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2
   } state_e;

   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_J     = 6'b000010;
   localparam logic [5:0] OPC_JAL   = 6'b000011;
   localparam logic [5:0] OPC_BEQ   = 6'b000100;
   localparam logic [5:0] OPC_BNE   = 6'b000101;
   localparam logic [5:0] FUNCT_JR  = 6'b001000;

   // Sign-extended word offset of a branch immediate, already shifted to bytes.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_pc_unit_pc_next_calc.sv
// Combinational next-PC selection: jr > j/jal > taken branch > sequential.
// Also flags a jr target that is not word aligned.
module pc_next_calc
   import fetch_pc_unit_pkg::*;
(
   input  logic [31:0]          pc,
   input  logic [TARGET_HI:0]   instr,
   input  logic                 jump_flag,
   input  logic                 branch_flag,
   input  logic                 jal_flag,
   input  logic                 jr_flag,
   input  logic                 branch_ne,
   input  logic                 alu_zero,
   input  logic [31:0]          rs_data,
   output logic [31:0]          next_pc,
   output logic                 target_misaligned
);

   logic [31:0] pc4_s;
   logic [31:0] jump_target_s;
   logic [31:0] branch_target_s;
   logic        branch_taken_s;

   assign pc4_s           = pc + 32'd4;
   assign jump_target_s   = {pc4_s[31:28], instr[TARGET_HI:TARGET_LO], 2'b00};
   assign branch_target_s = pc4_s + branch_offset(instr[IMM_HI:IMM_LO]);
   assign branch_taken_s  = branch_flag & (alu_zero ^ branch_ne);

   // Priority select of the next program counter.
   always_comb begin
      next_pc           = pc4_s;
      target_misaligned = 1'b0;
      if (jr_flag) begin
         next_pc           = rs_data;
         target_misaligned = (rs_data[1:0] != 2'b00);
      end else if (jump_flag || jal_flag) begin
         next_pc = jump_target_s;
      end else if (branch_taken_s) begin
         next_pc = branch_target_s;
      end else begin
         next_pc = pc4_s;
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction fetch and PC update unit: FETCH/EXEC/HALT FSM, PC and
// instruction registers, jal link write and sticky misaligned-jr error.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clock,
   input  logic                 reset,
   output logic                 imem_req,
   output logic [31:0]          imem_addr,
   input  logic                 imem_ready,
   input  logic [INSTR_W-1:0]   imem_data,
   output logic [INSTR_W-1:0]   instr,
   output logic                 instr_valid,
   output logic [5:0]           opcode,
   output logic [5:0]           funct,
   input  logic                 jump_flag,
   input  logic                 branch_flag,
   input  logic                 jal_flag,
   input  logic                 jr_flag,
   input  logic                 branch_ne,
   input  logic                 alu_zero,
   input  logic [31:0]          rs_data,
   input  logic                 stall,
   output logic [31:0]          pc,
   output logic [31:0]          link_addr,
   output logic                 link_we,
   output logic                 misaligned
);

   state_e              state_r;
   state_e              state_nxt_s;
   logic [31:0]         pc_r;
   logic [INSTR_W-1:0]  instr_r;
   logic                misaligned_r;
   logic                pc_load_s;
   logic                instr_load_s;
   logic                halt_set_s;
   logic                req_s;
   logic                valid_s;
   logic                link_we_s;
   logic [31:0]         next_pc_s;
   logic                target_misaligned_s;

   pc_next_calc u_pc_next_calc (
      .pc                (pc_r),
      .instr             (instr_r[TARGET_HI:0]),
      .jump_flag         (jump_flag),
      .branch_flag       (branch_flag),
      .jal_flag          (jal_flag),
      .jr_flag           (jr_flag),
      .branch_ne         (branch_ne),
      .alu_zero          (alu_zero),
      .rs_data           (rs_data),
      .next_pc           (next_pc_s),
      .target_misaligned (target_misaligned_s)
   );

   // State, PC, instruction and error registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r      <= FETCH;
         pc_r         <= RESET_PC;
         instr_r      <= {INSTR_W{1'b0}};
         misaligned_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (pc_load_s)    pc_r         <= next_pc_s;
         if (instr_load_s) instr_r      <= imem_data;
         if (halt_set_s)   misaligned_r <= 1'b1;
      end
   end

   // Next-state and per-state control decode.
   always_comb begin
      state_nxt_s  = state_r;
      pc_load_s    = 1'b0;
      instr_load_s = 1'b0;
      halt_set_s   = 1'b0;
      req_s        = 1'b0;
      valid_s      = 1'b0;
      link_we_s    = 1'b0;
      case (state_r)
         FETCH: begin
            req_s = 1'b1;
            if (imem_ready) begin
               instr_load_s = 1'b1;
               state_nxt_s  = EXEC;
            end else begin
               state_nxt_s = FETCH;
            end
         end
         EXEC: begin
            valid_s = 1'b1;
            if (stall) begin
               state_nxt_s = EXEC;
            end else if (target_misaligned_s) begin
               halt_set_s  = 1'b1;
               state_nxt_s = HALT;
            end else begin
               pc_load_s   = 1'b1;
               link_we_s   = jal_flag;
               state_nxt_s = FETCH;
            end
         end
         HALT: begin
            state_nxt_s = HALT;
         end
         default: begin
            state_nxt_s = FETCH;
         end
      endcase
   end

   // Reset overrides the handshake/write strobes in the same cycle it is seen.
   assign imem_req    = req_s & ~reset;
   assign instr_valid = valid_s & ~reset;
   assign link_we     = link_we_s & ~reset;
   assign imem_addr   = pc_r;
   assign pc          = pc_r;
   assign link_addr   = pc_r + 32'd4;
   assign instr       = instr_r;
   assign opcode      = instr_r[OPCODE_HI:OPCODE_LO];
   assign funct       = instr_r[FUNCT_HI:FUNCT_LO];
   assign misaligned  = misaligned_r;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit with hand-computed expectations.
module tb_fetch_pc_unit;

   logic        clock;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_data;
   logic [31:0] instr;
   logic        instr_valid;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        jump_flag;
   logic        branch_flag;
   logic        jal_flag;
   logic        jr_flag;
   logic        branch_ne;
   logic        alu_zero;
   logic [31:0] rs_data;
   logic        stall;
   logic [31:0] pc;
   logic [31:0] link_addr;
   logic        link_we;
   logic        misaligned;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [31:0] JR_WORD  = 32'h03E0_0008;
   localparam logic [31:0] BEQ_WORD = 32'h1000_FFFF;
   localparam logic [31:0] JAL_WORD = 32'h0C10_0010;

   fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clock(clock), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_data(imem_data), .instr(instr), .instr_valid(instr_valid),
      .opcode(opcode), .funct(funct),
      .jump_flag(jump_flag), .branch_flag(branch_flag), .jal_flag(jal_flag),
      .jr_flag(jr_flag), .branch_ne(branch_ne), .alu_zero(alu_zero),
      .rs_data(rs_data), .stall(stall), .pc(pc), .link_addr(link_addr),
      .link_we(link_we), .misaligned(misaligned)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_flags();
      jump_flag = 1'b0; branch_flag = 1'b0; jal_flag = 1'b0; jr_flag = 1'b0;
      branch_ne = 1'b0; alu_zero = 1'b0; stall = 1'b0; rs_data = 32'h0;
   endtask

   // From FETCH: take one word with immediate ready, ending in EXEC.
   task automatic fetch_word(input logic [31:0] w);
      imem_ready = 1'b1;
      imem_data  = w;
      tick();
      imem_ready = 1'b0;
      imem_data  = 32'hA5A5_A5A5;
   endtask

   // From FETCH: execute a jr to addr and check the new pc.
   task automatic jr_to(input logic [31:0] addr);
      fetch_word(JR_WORD);
      jr_flag = 1'b1;
      rs_data = addr;
      tick();
      clear_flags();
      settle();
      check("jr_pc", pc, addr);
   endtask

   initial begin
      reset = 1'b1; imem_ready = 1'b0; imem_data = 32'h0;
      clear_flags();
      tick(); tick();
      check("rst_req", {31'b0, imem_req}, 32'd0);
      check("rst_valid", {31'b0, instr_valid}, 32'd0);
      check("rst_pc", pc, 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_misaligned", {31'b0, misaligned}, 32'd0);

      // Test 1: first fetch and sequential advance
      reset = 1'b0; imem_ready = 1'b1; imem_data = 32'h2008_0005;
      settle();
      check("t1_req", {31'b0, imem_req}, 32'd1);
      check("t1_addr", imem_addr, 32'h0);
      tick();
      imem_ready = 1'b0;
      settle();
      check("t1_valid", {31'b0, instr_valid}, 32'd1);
      check("t1_opcode", {26'b0, opcode}, 32'h08);
      check("t1_instr", instr, 32'h2008_0005);
      check("t1_link_addr", link_addr, 32'h4);
      check("t1_req_exec", {31'b0, imem_req}, 32'd0);
      tick();
      check("t1_pc", pc, 32'h4);
      check("t1_valid_fetch", {31'b0, instr_valid}, 32'd0);

      // Test 5a: memory wait states hold request and address
      imem_data = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t5_wait_req", {31'b0, imem_req}, 32'd1);
         check("t5_wait_addr", imem_addr, 32'h4);
         check("t5_wait_valid", {31'b0, instr_valid}, 32'd0);
      end
      check("t5_wait_instr", instr, 32'h2008_0005);
      fetch_word(32'h0000_0000);
      check("t5_ready_valid", {31'b0, instr_valid}, 32'd1);
      check("t5_ready_instr", instr, 32'h0);
      tick();
      check("t5_pc", pc, 32'h8);

      // Test 2: branches
      jr_to(32'h10);
      fetch_word(BEQ_WORD);
      branch_flag = 1'b1; alu_zero = 1'b1;
      tick(); clear_flags();
      check("t2_beq_taken", pc, 32'h10);
      fetch_word(BEQ_WORD);
      branch_flag = 1'b1; alu_zero = 1'b0;
      tick(); clear_flags();
      check("t2_beq_not", pc, 32'h14);
      jr_to(32'h10);
      fetch_word(BEQ_WORD);
      branch_flag = 1'b1; branch_ne = 1'b1; alu_zero = 1'b0;
      tick(); clear_flags();
      check("t2_bne_taken", pc, 32'h10);

      // Test 3 + 5b: jal with two stall cycles
      jr_to(32'h0040_0020);
      fetch_word(JAL_WORD);
      jal_flag = 1'b1; stall = 1'b1;
      settle();
      check("t3_link_addr", link_addr, 32'h0040_0024);
      check("t3_link_we_stall0", {31'b0, link_we}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("t5_stall_pc", pc, 32'h0040_0020);
         check("t5_stall_link_we", {31'b0, link_we}, 32'd0);
         check("t5_stall_valid", {31'b0, instr_valid}, 32'd1);
      end
      stall = 1'b0;
      settle();
      check("t3_link_we_pulse", {31'b0, link_we}, 32'd1);
      tick();
      check("t3_jal_pc", pc, 32'h0040_0040);
      check("t3_link_we_fetch", {31'b0, link_we}, 32'd0);
      clear_flags();

      // Test 4a and 6a: aligned jr, then jr beats a taken branch
      jr_to(32'h100);
      fetch_word(BEQ_WORD);
      jr_flag = 1'b1; branch_flag = 1'b1; alu_zero = 1'b1; rs_data = 32'h200;
      tick(); clear_flags();
      check("t6_jr_priority", pc, 32'h200);

      // Test 6b: reset mid-FETCH with ready in the same cycle
      reset = 1'b1; imem_ready = 1'b1; imem_data = 32'hDEAD_BEEF;
      settle();
      check("t6_rst_req", {31'b0, imem_req}, 32'd0);
      tick();
      check("t6_rst_pc", pc, 32'h0);
      check("t6_rst_instr", instr, 32'h0);
      check("t6_rst_valid", {31'b0, instr_valid}, 32'd0);
      reset = 1'b0; imem_data = 32'h1234_5678;
      tick();
      imem_ready = 1'b0;
      check("t6_new_fetch", instr, 32'h1234_5678);
      check("t6_new_pc", pc, 32'h0);
      tick();
      check("t6_seq_pc", pc, 32'h4);

      // Reset mid-EXEC of a jal drops it without a link write
      fetch_word(JAL_WORD);
      jal_flag = 1'b1; reset = 1'b1;
      settle();
      check("rst_exec_link_we", {31'b0, link_we}, 32'd0);
      check("rst_exec_valid", {31'b0, instr_valid}, 32'd0);
      tick();
      reset = 1'b0; clear_flags();
      check("rst_exec_pc", pc, 32'h0);

      // Address wrap past the top of memory
      jr_to(32'hFFFF_FFFC);
      fetch_word(32'h0000_0000);
      tick();
      check("wrap_pc", pc, 32'h0);

      // Test 4b: misaligned jr halts until reset
      jr_to(32'h100);
      fetch_word(JR_WORD);
      jr_flag = 1'b1; rs_data = 32'h102;
      tick(); clear_flags();
      check("t4_misaligned", {31'b0, misaligned}, 32'd1);
      check("t4_halt_pc", pc, 32'h100);
      imem_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("t4_halt_req", {31'b0, imem_req}, 32'd0);
         check("t4_halt_valid", {31'b0, instr_valid}, 32'd0);
      end
      check("t4_halt_pc_hold", pc, 32'h100);
      imem_ready = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      settle();
      check("t4_rst_misaligned", {31'b0, misaligned}, 32'd0);
      check("t4_rst_pc", pc, 32'h0);
      check("t4_rst_req", {31'b0, imem_req}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction fetch and next-PC unit; the producer and consumer on the other side of the control unit (UC).
- Fetches an instruction word from instruction memory and presents opcode/funct to the UC.
- Samples the UC flags (jump_flag, branch_flag, jal_flag, jr_flag) plus the ALU result and updates the PC.
- Drives the $31 link write for jal.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
imem_req  out  1  fetch request.
imem_addr  out  32  fetch byte address; equals pc.
imem_ready  in  1  memory returns imem_data this cycle.
imem_data  in  32  instruction word.
instr  out  32  latched instruction.
instr_valid  out  1  instr valid for decode/execute.
opcode  out  6  instr[31:26], to UC.
funct  out  6  instr[5:0], to UC.
jump_flag  in  1  from UC.
branch_flag  in  1  from UC.
jal_flag  in  1  from UC.
jr_flag  in  1  from UC.
branch_ne  in  1  1 = bne, 0 = beq.
alu_zero  in  1  ALU zero result.
rs_data  in  32  register rs value (jr target).
stall  in  1  hold the current instruction in EXEC.
pc  out  32  current PC.
link_addr  out  32  pc+4.
link_we  out  1  write link_addr to $31.
misaligned  out  1  sticky jr-target error.

Behaviour:
- Synchronous reset, active-high; clock is the only clock.
- Reset values: state FETCH, pc = imem_addr = RESET_PC, instr = 0, misaligned = 0.
- While reset is high, all of the following are forced 0: imem_req, instr_valid, link_we.
- States:
  - FETCH: imem_req=1, imem_addr=pc. imem_ready is sampled only here. On imem_ready=1, latch imem_data into instr and go to EXEC; otherwise stay, holding addr stable.
  - EXEC: instr_valid=1; opcode/funct come from instr, so the UC flags are valid this cycle.
    - stall=1: stay in EXEC; pc, instr and outputs unchanged; link_we=0.
    - stall=0: load pc with next_pc and go to FETCH. If jal_flag, link_we=1 for exactly this cycle.
  - HALT: entered when the chosen jr target has [1:0]!=0. Sets misaligned=1 and leaves pc unchanged. Thereafter imem_req=0 and instr_valid=0. Only reset exits HALT.
- Latency: minimum 2 cycles per instruction (FETCH with immediate ready, then EXEC). Each memory wait cycle adds one; each stall cycle adds one.
- next_pc priority (highest first), applied when several flags are set:
  1. jr_flag: rs_data.
  2. jump_flag or jal_flag: {pc4[31:28], instr[25:0], 2'b00}.
  3. Branch taken: pc4 + (sign_extend(instr[15:0]) << 2). Taken = branch_flag & (alu_zero ^ branch_ne).
  4. Otherwise: pc4.
- pc4 = pc+4. All address arithmetic is mod 2^32; wrap past 32'hFFFF_FFFC goes to 0 silently.
- No branch delay slot. link_addr = pc4 is output combinationally at all times.
- Reset mid-FETCH: the outstanding request is abandoned; any imem_ready/imem_data in the following cycles is consumed only by the new FETCH at RESET_PC.
- Reset mid-EXEC: the instruction is dropped and no link_we is issued.
- Flags are ignored outside EXEC.

Decomposition:
- Shared package holds:
  - State encoding: FETCH, EXEC, HALT.
  - INSTR_W=32 and field slice positions: opcode 31:26, target 25:0, imm 15:0, funct 5:0.
  - Opcode constants: RTYPE 000000, J 000010, JAL 000011, BEQ 000100, BNE 000101, JR funct 001000.
- One combinational sub-module, pc_next_calc, with inputs pc, instr, flags, alu_zero, branch_ne and rs_data. Outputs: next_pc and target_misaligned.
- FSM and registers stay in fetch_pc_unit.

Test Plan:
1. Reset 2 cycles then release; imem_ready=1 with data 0x20080005 → req=1 at addr 0; next cycle instr_valid=1, opcode=001000. With flags 0 → pc=0x4.
2. Branches at pc=0x10, instr 0x1000FFFF, branch_flag=1:
   - beq, alu_zero=1 → pc=0x10.
   - beq, alu_zero=0 → pc=0x14.
   - bne, alu_zero=0 → pc=0x10.
3. jal at pc=0x0040_0020, instr 0x0C100010 → pc=0x0040_0040, link_addr=0x0040_0024, link_we high exactly one cycle.
4. jr:
   - rs_data=0x100 → pc=0x100.
   - rs_data=0x102 → misaligned=1, HALT, imem_req=0 for 10+ cycles until reset.
5. Wait and stall:
   - imem_ready low 3 cycles → req and addr stable, instr_valid only after ready.
   - stall high 2 cycles during jal EXEC → pc unchanged, link_we asserted only on the cycle stall drops.
6. Simultaneous jr_flag=1 and branch_flag=1 with alu_zero=1 → pc=rs_data. Separately, reset asserted mid-FETCH with imem_ready arriving the same cycle → pc=RESET_PC, instr unchanged at 0.
